// File: rtl/exe_issue_scheduler.sv
// Round-robin scheduler sharing one EXE datapath between two requesters, one op in flight.
// Optional performance counters are enabled with `define EXE_SCHED_PERF_EN.
module exe_issue_scheduler #(
  parameter int unsigned FLOAT_LAT = 4,
  parameter int unsigned TAG_W     = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_b_i,
  input  logic               flush_i,
  input  logic [1:0]         req_valid_i,
  output logic [1:0]         req_ready_o,
  input  logic [63:0]        req_a_i,
  input  logic [63:0]        req_b_i,
  input  logic [7:0]         req_control_i,
  input  logic [1:0]         req_alu_select_i,
  input  logic [2*TAG_W-1:0] req_tag_i,
  output logic [31:0]        exe_a_o,
  output logic [31:0]        exe_b_o,
  output logic [3:0]         exe_control_o,
  output logic               exe_alu_select_o,
  input  logic [31:0]        exe_alu_result_i,
  input  logic               exe_zero_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [31:0]        res_data_o,
  output logic               res_zero_o,
  output logic [TAG_W-1:0]   res_tag_o,
  output logic               res_id_o,
  output logic               busy_o
`ifdef EXE_SCHED_PERF_EN
  ,
  output logic [CNT_W-1:0]   perf_grant0_o,
  output logic [CNT_W-1:0]   perf_grant1_o,
  output logic [CNT_W-1:0]   perf_busy_o
`endif
);

  localparam int unsigned CntW = $clog2(FLOAT_LAT + 1);

  if (FLOAT_LAT < 1 || CNT_W < 1) begin : gen_param_check
    $error("FLOAT_LAT and CNT_W must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e            state_q, state_d;
  logic              rr_q;
  logic [CntW-1:0]   cnt_q;
  logic [31:0]       exe_a_q, exe_b_q, res_data_q;
  logic [3:0]        exe_ctl_q;
  logic              exe_sel_q, res_zero_q, res_id_q;
  logic [TAG_W-1:0]  res_tag_q;
  logic              gnt_any, gnt_id;

  // Arbitration: a lone requester always wins, on contention rr_q names the winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == StIdle && !flush_i && !rst_b_i) begin
      case (req_valid_i)
        2'b01: begin gnt_any = 1'b1; gnt_id = 1'b0; end
        2'b10: begin gnt_any = 1'b1; gnt_id = 1'b1; end
        2'b11: begin gnt_any = 1'b1; gnt_id = rr_q; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_b_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (gnt_any) state_d = StExec;
        StExec:  if (cnt_q == CntW'(1)) state_d = StDone;
        StDone:  if (res_ready_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    req_ready_o = 2'b00;
    if (gnt_any) req_ready_o = gnt_id ? 2'b10 : 2'b01;
    res_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
  end

  always_ff @(posedge clk_i) begin
    if (rst_b_i) begin
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      exe_a_q    <= '0;
      exe_b_q    <= '0;
      exe_ctl_q  <= '0;
      exe_sel_q  <= 1'b0;
      res_data_q <= '0;
      res_zero_q <= 1'b0;
      res_tag_q  <= '0;
      res_id_q   <= 1'b0;
    end else if (gnt_any) begin
      exe_a_q   <= gnt_id ? req_a_i[63:32] : req_a_i[31:0];
      exe_b_q   <= gnt_id ? req_b_i[63:32] : req_b_i[31:0];
      exe_ctl_q <= gnt_id ? req_control_i[7:4] : req_control_i[3:0];
      exe_sel_q <= req_alu_select_i[gnt_id];
      res_tag_q <= gnt_id ? req_tag_i[2*TAG_W-1:TAG_W] : req_tag_i[TAG_W-1:0];
      res_id_q  <= gnt_id;
      cnt_q     <= req_alu_select_i[gnt_id] ? CntW'(FLOAT_LAT) : CntW'(1);
      rr_q      <= ~gnt_id;
    end else if (state_q == StExec && !flush_i) begin
      cnt_q <= cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        res_data_q <= exe_alu_result_i;
        res_zero_q <= exe_zero_i;
      end
    end
  end

  assign exe_a_o          = exe_a_q;
  assign exe_b_o          = exe_b_q;
  assign exe_control_o    = exe_ctl_q;
  assign exe_alu_select_o = exe_sel_q;
  assign res_data_o       = res_data_q;
  assign res_zero_o       = res_zero_q;
  assign res_tag_o        = res_tag_q;
  assign res_id_o         = res_id_q;

`ifdef EXE_SCHED_PERF_EN
  logic [CNT_W-1:0] perf_grant0_q, perf_grant1_q, perf_busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_b_i) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_busy_q   <= '0;
    end else begin
      if (gnt_any && !gnt_id) perf_grant0_q <= perf_grant0_q + CNT_W'(1);
      if (gnt_any && gnt_id)  perf_grant1_q <= perf_grant1_q + CNT_W'(1);
      if (busy_o)             perf_busy_q   <= perf_busy_q + CNT_W'(1);
    end
  end

  assign perf_grant0_o = perf_grant0_q;
  assign perf_grant1_o = perf_grant1_q;
  assign perf_busy_o   = perf_busy_q;
`endif

endmodule

// File: tb/tb_exe_issue_scheduler.sv
// Directed bench for exe_issue_scheduler: transaction-level model plus literal spot checks.
module tb_exe_issue_scheduler;
  localparam int unsigned FLOAT_LAT = 4;
  localparam int unsigned TAG_W     = 4;

  logic              clk = 1'b0;
  logic              rst, flush, res_ready;
  logic [1:0]        req_valid, req_ready, req_alu_select;
  logic [63:0]       req_a, req_b;
  logic [7:0]        req_control;
  logic [2*TAG_W-1:0] req_tag;
  logic [31:0]       exe_a, exe_b, exe_res, res_data;
  logic [3:0]        exe_control;
  logic              exe_sel, exe_z, res_valid, res_zero, res_id, busy;
  logic [TAG_W-1:0]  res_tag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  exe_issue_scheduler #(.FLOAT_LAT(FLOAT_LAT), .TAG_W(TAG_W), .CNT_W(32)) dut (
    .clk_i(clk), .rst_b_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_control_i(req_control),
    .req_alu_select_i(req_alu_select), .req_tag_i(req_tag),
    .exe_a_o(exe_a), .exe_b_o(exe_b), .exe_control_o(exe_control),
    .exe_alu_select_o(exe_sel), .exe_alu_result_i(exe_res), .exe_zero_i(exe_z),
    .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
    .res_zero_o(res_zero), .res_tag_o(res_tag), .res_id_o(res_id), .busy_o(busy)
  );

  // EXE stage stand-in: int adds, float xors.
  always_comb begin
    exe_res = exe_sel ? (exe_a ^ exe_b) : (exe_a + exe_b);
    exe_z   = (exe_res == 32'd0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op, identified by its handshake cycle and latency.
  int          cyc = 0;
  bit          m_busy = 1'b0;
  bit          m_prio = 1'b0;
  int          m_hs, m_lat;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_ctl;
  logic        m_sel, m_id;
  logic [TAG_W-1:0] m_tag;

  always @(posedge clk) begin
    bit g;
    if (rst) begin
      m_busy = 1'b0;
      m_prio = 1'b0;
    end else if (flush) begin
      m_busy = 1'b0;
    end else if (!m_busy && req_valid != 2'b00) begin
      g      = (req_valid == 2'b11) ? m_prio : req_valid[1];
      m_busy = 1'b1;
      m_hs   = cyc;
      m_a    = req_a[32*g +: 32];
      m_b    = req_b[32*g +: 32];
      m_ctl  = req_control[4*g +: 4];
      m_sel  = req_alu_select[g];
      m_tag  = req_tag[TAG_W*g +: TAG_W];
      m_id   = g;
      m_lat  = m_sel ? FLOAT_LAT : 1;
      m_prio = ~g;
    end else if (m_busy && cyc >= m_hs + 1 + m_lat && res_ready) begin
      m_busy = 1'b0;
    end
    cyc++;
  end

  always @(negedge clk) begin
    logic [1:0]  exp_ready;
    logic [31:0] exp_res;
    bit          done, exec;
    exp_ready = 2'b00;
    if (!m_busy && !flush && !rst && req_valid != 2'b00)
      exp_ready = (req_valid == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : req_valid;
    done = m_busy && (cyc >= m_hs + 1 + m_lat);
    exec = m_busy && (cyc >= m_hs + 1) && (cyc <= m_hs + m_lat);
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("res_valid", 64'(res_valid), 64'(done));
    if (done) begin
      exp_res = m_sel ? (m_a ^ m_b) : (m_a + m_b);
      chk("res_data", 64'(res_data), 64'(exp_res));
      chk("res_zero", 64'(res_zero), 64'(exp_res == 32'd0));
      chk("res_tag", 64'(res_tag), 64'(m_tag));
      chk("res_id", 64'(res_id), 64'(m_id));
    end
    if (exec) begin
      chk("exe_a", 64'(exe_a), 64'(m_a));
      chk("exe_b", 64'(exe_b), 64'(m_b));
      chk("exe_control", 64'(exe_control), 64'(m_ctl));
      chk("exe_alu_select", 64'(exe_sel), 64'(m_sel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request and hold it until granted; returns just after the handshake edge.
  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctl, input logic sel, input logic [TAG_W-1:0] tag);
    bit got = 1'b0;
    req_a[32*i +: 32]         = a;
    req_b[32*i +: 32]         = b;
    req_control[4*i +: 4]     = ctl;
    req_alu_select[i]         = sel;
    req_tag[TAG_W*i +: TAG_W] = tag;
    req_valid[i]              = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: requester %0d got no grant, expected one within 30 cycles", i);
    end
    tick();
    req_valid[i] = 1'b0;
  endtask

  initial begin
    int gc[4];
    int gi[4];
    int ng;
    bit got;
    rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_control = '0;
    req_alu_select = '0; req_tag = '0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_exe_a", 64'(exe_a), 64'd0);
    chk("rst_exe_ctl", 64'(exe_control), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_tag", 64'(res_tag), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();

    // Single int op: 5+3
    issue(0, 32'd5, 32'd3, 4'd2, 1'b0, 4'd7);
    @(negedge clk);
    chk("t2_early_valid", 64'(res_valid), 64'd0);
    tick();
    @(negedge clk);
    chk("t2_valid", 64'(res_valid), 64'd1);
    chk("t2_data", 64'(res_data), 64'd8);
    chk("t2_zero", 64'(res_zero), 64'd0);
    chk("t2_tag", 64'(res_tag), 64'd7);
    chk("t2_id", 64'(res_id), 64'd0);
    tick();

    // Round robin under contention, pointer freshly reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_a = {32'd100, 32'd1}; req_b = {32'd200, 32'd2};
    req_alu_select = 2'b00; req_control = 8'h43; req_tag = {4'd2, 4'd1};
    req_valid = 2'b11;
    ng = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00 && ng < 4) begin
        gc[ng] = k;
        gi[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      tick();
    end
    req_valid = 2'b00;
    chk("t3_ngrants", 64'(ng), 64'd4);
    for (int k = 0; k < ng; k++) chk("t3_order", 64'(gi[k]), 64'(k % 2));
    for (int k = 1; k < ng; k++) chk("t3_spacing", 64'(gc[k] - gc[k-1]), 64'd3);

    // Float op: 1.0 ^ 1.0 -> 0
    issue(1, 32'h3F800000, 32'h3F800000, 4'd5, 1'b1, 4'd9);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t4_exe_a", 64'(exe_a), 64'h3F800000);
      chk("t4_exe_b", 64'(exe_b), 64'h3F800000);
      chk("t4_exe_sel", 64'(exe_sel), 64'd1);
      chk("t4_no_valid", 64'(res_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("t4_valid", 64'(res_valid), 64'd1);
    chk("t4_data", 64'(res_data), 64'd0);
    chk("t4_zero", 64'(res_zero), 64'd1);
    chk("t4_id", 64'(res_id), 64'd1);
    tick();

    // Backpressure in DONE while another request waits
    res_ready = 1'b0;
    issue(0, 32'd10, 32'd20, 4'd1, 1'b0, 4'd3);
    req_a[63:32] = 32'd7; req_b[63:32] = 32'd8; req_alu_select[1] = 1'b0; req_tag[7:4] = 4'd4;
    req_valid[1] = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_held_valid", 64'(res_valid), 64'd1);
      chk("t5_held_data", 64'(res_data), 64'd30);
      chk("t5_no_ready", 64'(req_ready), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("t5_accept_valid", 64'(res_valid), 64'd1);
    tick();
    @(negedge clk);
    chk("t5_next_grant", 64'(req_ready), 64'b10);
    tick();
    req_valid[1] = 1'b0;
    repeat (4) tick();

    // Flush in EXEC cycle 2 of a float op
    issue(0, 32'd1, 32'd2, 4'd6, 1'b1, 4'd5);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t6_flush_busy", 64'(busy), 64'd0);
      chk("t6_flush_no_res", 64'(res_valid), 64'd0);
      tick();
    end

    // Same with reset: pointer (now favouring req1) returns to req0
    issue(0, 32'd1, 32'd2, 4'd6, 1'b1, 4'd5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = 2'b10;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[1]) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("t6_req1_served", 64'(got), 64'd1);
    tick();
    req_valid = 2'b00;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
